program_loader: RTL and testbench
=================================

# program_loader

Boot-time loader that fills the RISC-V core's 256-word instruction memory from a byte stream (UART receiver side), then releases the core. It sits between the serial receiver and the instruction memory's write port and drives the core's reset. It holds the core in reset while loading, assembles little-endian words, writes them at `TEXT + 4*i`, verifies a checksum, and reports done or error.

## Interface
- `TEXT`, 32'h0040_0000, byte address of instruction word 0 (same base the fetch path subtracts).
- `DEPTH`, 256, instruction memory depth in words; maximum accepted word count.
- `clock`  in  1  sole clock, rising edge.
- `reset`  in  1  synchronous, active-high.
- `rx_data`  in  8  incoming byte.
- `rx_valid`  in  1  `rx_data` valid.
- `rx_ready`  out  1  loader accepts a byte this cycle; transfer occurs when `rx_valid && rx_ready`.
- `start`  in  1  one-cycle pulse: abort anything in progress and begin a new load.
- `imem_we`  out  1  instruction memory write strobe, one cycle per word.
- `imem_addr`  out  32  byte address of write.
- `imem_wdata`  out  32  word to write.
- `cpu_reset`  out  1  holds the core in reset while high.
- `busy`  out  1  load in progress (LEN0..CSUM).
- `done`  out  1  last load succeeded; level, not pulse.
- `error`  out  1  last load failed; level.

## Operation
- Frame format: `N[7:0]`, `N[15:8]`, then N×4 data bytes (LSB first per word), then a 1-byte checksum. The checksum is the sum of all data bytes mod 256; header bytes are excluded.
- States:
  - LEN0: low length byte → LEN1.
  - LEN1: high length byte.
    - If N > DEPTH → ERROR.
    - If N == 0 → CSUM.
    - Else → DATA.
  - DATA: collects 4 bytes; on the 4th → WRITE.
  - WRITE: asserts the write for one cycle, then increments index i. If i+1 == N → CSUM, else → DATA.
  - CSUM: compares the received byte with the accumulated sum. Match → DONE, mismatch → ERROR.
  - DONE / ERROR: idle until `start`.
- `rx_ready` = 1 in LEN0, LEN1, DATA, CSUM; 0 in WRITE, DONE, ERROR. A byte presented during WRITE is held by the source and accepted the cycle after.
- `imem_we` = 1 only in WRITE:
  - `imem_addr` = TEXT + (i << 2), with i a 9-bit index (0..255).
  - `imem_wdata` = {b3,b2,b1,b0}.
- `cpu_reset` = 0 only in DONE.
- `done` = (state == DONE); `error` = (state == ERROR).
- Running sum is 8 bits and wraps; it is cleared on entry to LEN0.
- `start` has priority over every state, including mid-word and WRITE:
  - → LEN0; i, byte count and sum are cleared.
  - A byte accepted in the same cycle is discarded.
  - Words already written are not erased.
- `reset` behaves like `start`. Reset values: state LEN0, `rx_ready`=1, `cpu_reset`=1, `busy`=1, `imem_we`=0, `imem_addr`=TEXT, `imem_wdata`=0, `done`=0, `error`=0.
- N == DEPTH is legal; the last write goes to TEXT+0x3FC.

## Timing
- All outputs are registered or decoded from registered state; no combinational path from `rx_valid` to any output.
- The 4th byte of a word is accepted at edge k. `imem_we` is high in cycle k+1 and `rx_ready` is low in cycle k+1. The next byte can be accepted at edge k+2.
- Checksum byte accepted at edge k: `done` or `error` is high from cycle k+1. In the DONE case, `cpu_reset` falls in that same cycle.
- Minimum frame time with continuous `rx_valid`: 3 + 5N cycles from the first accepted byte to DONE.
- `start` sampled at edge k: state is LEN0 in cycle k+1, with `cpu_reset`=1 and `done`/`error`=0.

## Structure
- Shared package/header holds the state encoding (7 states, 3 bits) and the `TEXT`/`DEPTH` defaults, shared with the fetch path.
- One natural sub-module, `word_assembler`: a 2-bit byte counter plus a 32-bit shift register. Its outputs are the assembled word and a `word_full` flag; it has a clear input driven by `start`/`reset`.

## Test plan
- Normal load. Send `02 00 37 04 01 10 83 24 44 00 37` → two writes: (0x00400000, 0x10010437) and (0x00400004, 0x00442483). Then `done`=1, `cpu_reset`=0, `error`=0.
- Empty frame. Send `00 00 00` → no `imem_we`; `done`=1 two cycles... exactly one cycle after the checksum byte is accepted.
- Oversize. Send `01 01` (N=257) → ERROR: `rx_ready`=0, no writes, `cpu_reset`=1. A `start` pulse then returns to LEN0 with `error`=0.
- Bad checksum. Repeat the normal load with a final byte of 0x38 → both writes still occur. Then `error`=1, `done`=0, `cpu_reset`=1.
- Backpressure. Hold `rx_valid`=1 continuously, with a new byte every accepted cycle → WRITE cycles show `rx_ready`=0 and no byte is lost or duplicated. Also insert random `rx_valid` gaps → identical writes.
- Abort. Pulse `start` after 6 data bytes → LEN0 with index 0. The subsequent full frame writes from 0x00400000. Repeat the same sequence using `reset` instead of `start`.

Source files
------------

// File: rtl/program_loader_pkg.sv
`default_nettype none
// ============================================================================
// Module      : program_loader_pkg
// Description : Shared constants for the boot loader and the fetch path:
//               instruction memory base/depth and the loader state encoding.
// Revision    : 1.0 - initial release
// ============================================================================
package program_loader_pkg;

    // Byte address of instruction word 0; the fetch path subtracts the same base.
    localparam logic [31:0] c_TEXT_DEFAULT  = 32'h0040_0000;
    // Instruction memory depth in words.
    localparam int          c_DEPTH_DEFAULT = 256;

    // Loader state encoding (7 states, 3 bits).
    localparam logic [2:0] c_ST_LEN0  = 3'd0;
    localparam logic [2:0] c_ST_LEN1  = 3'd1;
    localparam logic [2:0] c_ST_DATA  = 3'd2;
    localparam logic [2:0] c_ST_WRITE = 3'd3;
    localparam logic [2:0] c_ST_CSUM  = 3'd4;
    localparam logic [2:0] c_ST_DONE  = 3'd5;
    localparam logic [2:0] c_ST_ERROR = 3'd6;

    // States in which the loader consumes bytes from the receiver.
    function automatic logic accepts_bytes(input logic [2:0] st);
        return (st == c_ST_LEN0) || (st == c_ST_LEN1) ||
               (st == c_ST_DATA) || (st == c_ST_CSUM);
    endfunction

endpackage
`default_nettype wire

// File: rtl/program_loader_word_assembler.sv
`default_nettype none
// ============================================================================
// Module      : word_assembler
// Description : Packs four bytes (LSB first) into a little-endian 32-bit word.
//               o_word_full flags the byte that completes a word.
// Revision    : 1.0 - initial release
// ============================================================================
module word_assembler (
    input  logic        clk,
    input  logic        rst,
    input  logic        i_clear,
    input  logic        i_byte_valid,
    input  logic [7:0]  i_byte,
    output logic [31:0] o_word,
    output logic        o_word_full
);

    logic [1:0]  r_cnt;
    logic [31:0] r_word;

    // Shift each new byte in from the top so byte 0 ends up in bits [7:0].
    always_ff @(posedge clk) begin
        if (rst || i_clear) begin
            r_cnt  <= 2'd0;
            r_word <= 32'd0;
        end else if (i_byte_valid) begin
            r_cnt  <= r_cnt + 2'd1;
            r_word <= {i_byte, r_word[31:8]};
        end
    end

    assign o_word      = r_word;
    assign o_word_full = i_byte_valid && (r_cnt == 2'd3);

endmodule
`default_nettype wire

// File: rtl/program_loader.sv
`default_nettype none
// ============================================================================
// Module      : program_loader
// Description : Boot-time loader. Receives a length-prefixed byte frame,
//               writes little-endian words to instruction memory at TEXT+4*i,
//               verifies an 8-bit data checksum and releases the core.
// Revision    : 1.0 - initial release
// ============================================================================
module program_loader
    import program_loader_pkg::*;
#(
    parameter logic [31:0] TEXT  = c_TEXT_DEFAULT,
    parameter int          DEPTH = c_DEPTH_DEFAULT
) (
    input  logic        clock,
    input  logic        reset,
    input  logic [7:0]  rx_data,
    input  logic        rx_valid,
    output logic        rx_ready,
    input  logic        start,
    output logic        imem_we,
    output logic [31:0] imem_addr,
    output logic [31:0] imem_wdata,
    output logic        cpu_reset,
    output logic        busy,
    output logic        done,
    output logic        error
);

    localparam logic [15:0] c_DEPTH16 = 16'(DEPTH);

    logic [2:0]  r_state;
    logic [15:0] r_len;
    logic [8:0]  r_idx;
    logic [7:0]  r_sum;

    logic        w_accept;
    logic        w_byte_valid;
    logic        w_word_full;
    logic [31:0] w_word;
    logic [15:0] w_len_full;
    logic [8:0]  w_idx_next;
    logic        w_last_word;

    assign w_accept     = rx_valid && rx_ready;
    assign w_byte_valid = w_accept && (r_state == c_ST_DATA);
    assign w_len_full   = {rx_data, r_len[7:0]};
    assign w_idx_next   = r_idx + 9'd1;
    assign w_last_word  = ({7'd0, w_idx_next} == r_len);

    // Data-byte packing; a start pulse also discards any partial word.
    word_assembler u_word_assembler (
        .clk          (clock),
        .rst          (reset),
        .i_clear      (start),
        .i_byte_valid (w_byte_valid),
        .i_byte       (rx_data),
        .o_word       (w_word),
        .o_word_full  (w_word_full)
    );

    // Frame sequencing; start/reset abort everything and discard a same-cycle byte.
    always_ff @(posedge clock) begin
        if (reset || start) begin
            r_state <= c_ST_LEN0;
            r_len   <= 16'd0;
            r_idx   <= 9'd0;
            r_sum   <= 8'd0;
        end else begin
            case (r_state)
                c_ST_LEN0: begin
                    if (w_accept) begin
                        r_len[7:0] <= rx_data;
                        r_state    <= c_ST_LEN1;
                    end
                end
                c_ST_LEN1: begin
                    if (w_accept) begin
                        r_len[15:8] <= rx_data;
                        if (w_len_full > c_DEPTH16) begin
                            r_state <= c_ST_ERROR;
                        end else if (w_len_full == 16'd0) begin
                            r_state <= c_ST_CSUM;
                        end else begin
                            r_state <= c_ST_DATA;
                        end
                    end
                end
                c_ST_DATA: begin
                    if (w_accept) begin
                        r_sum <= r_sum + rx_data;
                        if (w_word_full) begin
                            r_state <= c_ST_WRITE;
                        end
                    end
                end
                c_ST_WRITE: begin
                    r_idx   <= w_idx_next;
                    r_state <= w_last_word ? c_ST_CSUM : c_ST_DATA;
                end
                c_ST_CSUM: begin
                    if (w_accept) begin
                        r_state <= (rx_data == r_sum) ? c_ST_DONE : c_ST_ERROR;
                    end
                end
                c_ST_DONE:  r_state <= c_ST_DONE;
                c_ST_ERROR: r_state <= c_ST_ERROR;
                default:    r_state <= c_ST_LEN0;
            endcase
        end
    end

    // Every output is a decode of registered state, so rx_valid never reaches an output.
    always_comb begin
        rx_ready   = accepts_bytes(r_state);
        imem_we    = (r_state == c_ST_WRITE);
        imem_addr  = TEXT + {21'd0, r_idx, 2'b00};
        imem_wdata = imem_we ? w_word : 32'd0;
        busy       = (r_state != c_ST_DONE) && (r_state != c_ST_ERROR);
        done       = (r_state == c_ST_DONE);
        error      = (r_state == c_ST_ERROR);
        cpu_reset  = (r_state != c_ST_DONE);
    end

endmodule
`default_nettype wire

// File: tb/tb_program_loader.sv
`default_nettype none
// ============================================================================
// Module      : tb_program_loader
// Description : Directed self-checking bench for program_loader.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_program_loader;

    typedef logic [7:0] byte_q_t [$];

    localparam logic [31:0] c_BASE = 32'h0040_0000;

    logic        clock    = 1'b0;
    logic        reset    = 1'b1;
    logic        start    = 1'b0;
    logic        rx_valid = 1'b0;
    logic [7:0]  rx_data  = 8'd0;
    logic        rx_ready;
    logic        imem_we;
    logic [31:0] imem_addr;
    logic [31:0] imem_wdata;
    logic        cpu_reset;
    logic        busy;
    logic        done;
    logic        error;

    int checks     = 0;
    int errors     = 0;
    int we_rdy_bad = 0;

    logic [31:0] wa [$];
    logic [31:0] wd [$];

    program_loader dut (
        .clock      (clock),
        .reset      (reset),
        .rx_data    (rx_data),
        .rx_valid   (rx_valid),
        .rx_ready   (rx_ready),
        .start      (start),
        .imem_we    (imem_we),
        .imem_addr  (imem_addr),
        .imem_wdata (imem_wdata),
        .cpu_reset  (cpu_reset),
        .busy       (busy),
        .done       (done),
        .error      (error)
    );

    always #5 clock = ~clock;

    // Log every memory write, sampled mid-cycle.
    always @(negedge clock) begin
        if (imem_we) begin
            wa.push_back(imem_addr);
            wd.push_back(imem_wdata);
            if (rx_ready) we_rdy_bad++;
        end
    end

    initial begin
        #1000000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] qget(input logic [31:0] q [$], input int i);
        return (i < q.size()) ? q[i] : 32'hxxxx_xxxx;
    endfunction

    // Present one byte (after an optional idle gap) and hold it until accepted.
    task automatic send_byte(input logic [7:0] b, input int gap);
        logic acc;
        acc = 1'b0;
        repeat (gap) begin @(posedge clock); #1; end
        rx_data  = b;
        rx_valid = 1'b1;
        for (int t = 0; t < 50 && !acc; t++) begin
            @(negedge clock);
            acc = rx_ready;
            @(posedge clock);
            #1;
        end
        rx_valid = 1'b0;
        if (!acc) check("rx_accept_timeout", {31'd0, acc}, 32'd1);
    endtask

    task automatic send_frame(input byte_q_t q, input logic gaps);
        foreach (q[i]) send_byte(q[i], gaps ? int'($urandom_range(0, 3)) : 0);
    endtask

    task automatic pulse_start();
        start = 1'b1;
        @(posedge clock); #1;
        start = 1'b0;
    endtask

    task automatic pulse_reset();
        reset = 1'b1;
        @(posedge clock); #1;
        reset = 1'b0;
    endtask

    task automatic clear_log();
        wa.delete();
        wd.delete();
    endtask

    task automatic check_normal_writes(input string tag);
        check({tag, "_nwr"},   wa.size(),   32'd2);
        check({tag, "_addr0"}, qget(wa, 0), 32'h0040_0000);
        check({tag, "_data0"}, qget(wd, 0), 32'h1001_0437);
        check({tag, "_addr1"}, qget(wa, 1), 32'h0040_0004);
        check({tag, "_data1"}, qget(wd, 1), 32'h0044_2483);
    endtask

    byte_q_t nf;
    byte_q_t bad;
    byte_q_t part;
    byte_q_t big;
    logic [7:0] bsum;

    initial begin
        nf   = {8'h02, 8'h00, 8'h37, 8'h04, 8'h01, 8'h10, 8'h83, 8'h24, 8'h44, 8'h00, 8'h37};
        bad  = {8'h02, 8'h00, 8'h37, 8'h04, 8'h01, 8'h10, 8'h83, 8'h24, 8'h44, 8'h00, 8'h38};
        part = {8'h02, 8'h00, 8'h37, 8'h04, 8'h01, 8'h10, 8'h83, 8'h24};

        // Reset state
        repeat (2) @(posedge clock);
        #1;
        check("rst_rx_ready",  rx_ready,   32'd1);
        check("rst_cpu_reset", cpu_reset,  32'd1);
        check("rst_busy",      busy,       32'd1);
        check("rst_we",        imem_we,    32'd0);
        check("rst_addr",      imem_addr,  c_BASE);
        check("rst_wdata",     imem_wdata, 32'd0);
        check("rst_done",      done,       32'd0);
        check("rst_error",     error,      32'd0);
        reset = 1'b0;
        @(posedge clock); #1;

        // Normal load, continuous rx_valid
        clear_log();
        send_frame(nf, 1'b0);
        check("norm_done",      done,      32'd1);
        check("norm_error",     error,     32'd0);
        check("norm_cpu_reset", cpu_reset, 32'd0);
        check("norm_busy",      busy,      32'd0);
        check("norm_rx_ready",  rx_ready,  32'd0);
        check_normal_writes("norm");

        // Start returns to LEN0 and holds the core again
        pulse_start();
        check("start_done",      done,      32'd0);
        check("start_cpu_reset", cpu_reset, 32'd1);
        check("start_rx_ready",  rx_ready,  32'd1);
        check("start_addr",      imem_addr, c_BASE);

        // Empty frame: done one cycle after the checksum byte
        clear_log();
        send_frame({8'h00, 8'h00, 8'h00}, 1'b0);
        check("empty_done",  done,      32'd1);
        check("empty_nwr",   wa.size(), 32'd0);

        // Oversize length
        pulse_start();
        clear_log();
        send_frame({8'h01, 8'h01}, 1'b0);
        check("over_error",     error,     32'd1);
        check("over_rx_ready",  rx_ready,  32'd0);
        check("over_cpu_reset", cpu_reset, 32'd1);
        repeat (3) @(posedge clock);
        #1;
        check("over_nwr",       wa.size(), 32'd0);
        pulse_start();
        check("over_clr_error", error,     32'd0);
        check("over_clr_ready", rx_ready,  32'd1);

        // Bad checksum: writes still happen, then ERROR
        clear_log();
        send_frame(bad, 1'b0);
        check("bad_error",     error,     32'd1);
        check("bad_done",      done,      32'd0);
        check("bad_cpu_reset", cpu_reset, 32'd1);
        check_normal_writes("bad");

        // Random rx_valid gaps give identical writes
        pulse_start();
        clear_log();
        send_frame(nf, 1'b1);
        check("gap_done", done, 32'd1);
        check_normal_writes("gap");

        // Abort with start after 6 data bytes
        pulse_start();
        send_frame(part, 1'b0);
        pulse_start();
        check("abort_addr",  imem_addr, c_BASE);
        check("abort_busy",  busy,      32'd1);
        check("abort_ready", rx_ready,  32'd1);
        clear_log();
        send_frame(nf, 1'b0);
        check("abort_done", done, 32'd1);
        check_normal_writes("abort");

        // Abort with reset after 6 data bytes
        pulse_start();
        send_frame(part, 1'b0);
        pulse_reset();
        check("rabort_addr", imem_addr, c_BASE);
        check("rabort_done", done,      32'd0);
        clear_log();
        send_frame(nf, 1'b0);
        check("rabort_done2", done, 32'd1);
        check_normal_writes("rabort");

        // N == DEPTH: every byte of word i is i, last write at TEXT+0x3FC
        big  = {8'h00, 8'h01};
        bsum = 8'd0;
        for (int i = 0; i < 256; i++) begin
            for (int k = 0; k < 4; k++) begin
                big.push_back(8'(i));
                bsum = bsum + 8'(i);
            end
        end
        big.push_back(bsum);
        pulse_start();
        clear_log();
        send_frame(big, 1'b0);
        check("full_done",  done,          32'd1);
        check("full_nwr",   wa.size(),     32'd256);
        check("full_addr1", qget(wa, 1),   32'h0040_0004);
        check("full_data1", qget(wd, 1),   32'h0101_0101);
        check("full_last",  qget(wa, 255), 32'h0040_03FC);
        check("full_dlast", qget(wd, 255), 32'hFFFF_FFFF);

        check("we_with_ready", we_rdy_bad, 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
